// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID pipeline register and its slot registers.
// Combinational only: constants, types and a state-decode helper.
package ifid_pkg;

    localparam int          IFID_XLEN      = 32;
    localparam logic [31:0] IFID_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } ifid_state_e;

    typedef struct packed {
        logic [IFID_XLEN-1:0] instr;
        logic [IFID_XLEN-1:0] pc;
        logic                 valid;
    } ifid_slot_t;

    // Occupancy is fully described by the two slot valid bits.
    function automatic ifid_state_e slot_state(input logic main_vld, input logic skid_vld);
        if (!main_vld)
            return ST_EMPTY;
        return skid_vld ? ST_TWO : ST_ONE;
    endfunction

endpackage

// File: rtl/ifid_pipe_reg_if.sv
// Fetch-to-decode bundle: fetch data in, hazard controls in, decode data out.
// master = fetch/hazard side, slave = the IF/ID register.
interface ifid_pipe_reg_if
    import ifid_pkg::*;
#(
    parameter int XLEN = IFID_XLEN
);
    logic [XLEN-1:0] instr_in;
    logic [XLEN-1:0] pc_in;
    logic            valid_in;
    logic            in_ready;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] pc_out;
    logic            valid_out;

    modport master (
        output instr_in, pc_in, valid_in, stall, flush,
        input  in_ready, instr_out, pc_out, valid_out
    );

    modport slave (
        input  instr_in, pc_in, valid_in, stall, flush,
        output in_ready, instr_out, pc_out, valid_out
    );

endinterface

// File: rtl/pipe_skid_slot.sv
// One {instr, pc, valid} register with clear (priority) and load; otherwise holds.
// Latency 1 cycle; no backpressure of its own, the caller decides when to load.
module pipe_skid_slot
    import ifid_pkg::*;
#(
    parameter int              XLEN      = IFID_XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(IFID_NOP_INSTR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic            valid_d,
    output logic [XLEN-1:0] instr_q,
    output logic [XLEN-1:0] pc_q,
    output logic            valid_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/ifid_pipe_reg.sv
// IF/ID register with one-entry skid, flush-to-bubble and saturating stall counter.
// Latency 1 cycle (skidded entries wait for the first unstalled edge); in_ready drops while the skid is full.
module ifid_pipe_reg
    import ifid_pkg::*;
#(
    parameter int              XLEN      = IFID_XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(IFID_NOP_INSTR),
    parameter int              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    ifid_pipe_reg_if.slave    bus,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [XLEN-1:0] main_instr, main_pc, skid_instr, skid_pc;
    logic            main_vld, skid_vld;

    logic [XLEN-1:0] main_instr_d, main_pc_d;
    logic            main_vld_d;
    logic            main_load, main_clr, skid_load, skid_clr;
    logic            accept;
    ifid_state_e     state;

    always_comb begin
        main_instr_d = bus.instr_in;
        main_pc_d    = bus.pc_in;
        main_vld_d   = 1'b1;
        main_load    = 1'b0;
        main_clr     = 1'b0;
        skid_load    = 1'b0;
        skid_clr     = 1'b0;
        state        = slot_state(main_vld, skid_vld);
        accept       = bus.valid_in && !skid_vld;

        if (bus.flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (!bus.stall) begin
            main_load = 1'b1;
            case (state)
                ST_TWO: begin
                    main_instr_d = skid_instr;
                    main_pc_d    = skid_pc;
                    skid_clr     = 1'b1;
                end
                default: begin
                    // Nothing to advance: decode sees a bubble that keeps the last PC.
                    if (!accept) begin
                        main_instr_d = NOP_INSTR;
                        main_pc_d    = main_pc;
                        main_vld_d   = 1'b0;
                    end
                end
            endcase
        end else begin
            case (state)
                ST_EMPTY: main_load = accept;
                ST_ONE:   skid_load = accept;
                default:  ;
            endcase
        end
    end

    pipe_skid_slot #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (main_load),
        .clear   (main_clr),
        .instr_d (main_instr_d),
        .pc_d    (main_pc_d),
        .valid_d (main_vld_d),
        .instr_q (main_instr),
        .pc_q    (main_pc),
        .valid_q (main_vld)
    );

    pipe_skid_slot #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clr),
        .instr_d (bus.instr_in),
        .pc_d    (bus.pc_in),
        .valid_d (1'b1),
        .instr_q (skid_instr),
        .pc_q    (skid_pc),
        .valid_q (skid_vld)
    );

    // Counts decode-stall cycles on real instructions; flush does not touch it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (bus.stall && main_vld && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.instr_out = main_instr;
    assign bus.pc_out    = main_pc;
    assign bus.valid_out = main_vld;
    assign bus.in_ready  = !skid_vld;

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Bench for ifid_pipe_reg: directed scenarios plus random traffic against a queue-based model.
module tb_ifid_pipe_reg;
    import ifid_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [CNT_W-1:0] stall_cnt;

    ifid_pipe_reg_if #(.XLEN(XLEN)) bus ();

    ifid_pipe_reg #(.XLEN(XLEN), .NOP_INSTR(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: ordered list of held instructions (front is what decode sees).
    ifid_slot_t  mq[$];
    logic [31:0] m_pc;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = '0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        bit         vo;
        bit         acc;
        ifid_slot_t e;
        vo  = (mq.size() > 0);
        acc = bus.valid_in && (mq.size() < 2);
        e   = '{instr: bus.instr_in, pc: bus.pc_in, valid: 1'b1};
        if (bus.stall && vo && m_cnt < CNT_MAX)
            m_cnt++;
        if (bus.flush) begin
            mq.delete();
            m_pc = '0;
        end else if (!bus.stall) begin
            if (mq.size() == 2) begin
                void'(mq.pop_front());
            end else begin
                if (mq.size() == 1) void'(mq.pop_front());
                if (acc) mq.push_back(e);
            end
        end else if (acc) begin
            mq.push_back(e);
        end
        if (mq.size() > 0)
            m_pc = mq[0].pc;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid_out"}, 32'(bus.valid_out), 32'(mq.size() > 0));
        check({tag, ".instr_out"}, bus.instr_out, (mq.size() > 0) ? mq[0].instr : 32'h0);
        check({tag, ".pc_out"},    bus.pc_out, m_pc);
        check({tag, ".in_ready"},  32'(bus.in_ready), 32'(mq.size() < 2));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic drive(input bit v, input logic [31:0] i, input logic [31:0] p,
                         input bit st, input bit fl);
        bus.valid_in = v;
        bus.instr_in = i;
        bus.pc_in    = p;
        bus.stall    = st;
        bus.flush    = fl;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1 reset = 1'b0;
    endtask

    initial begin
        drive(0, 32'h0, 32'h0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Stream two instructions, no stall.
        drive(1, 32'h2008_0005, 32'd4, 0, 0);
        step("stream0");
        check("stream0.lit", bus.instr_out, 32'h2008_0005);
        drive(1, 32'h2009_0003, 32'd8, 0, 0);
        step("stream1");
        check("stream1.lit", bus.instr_out, 32'h2009_0003);

        // Late stall: ONE holding 0x20080005, skid catches 0x20090003.
        drive(1, 32'h2008_0005, 32'd4, 0, 0);
        step("ls_fill");
        drive(1, 32'h2009_0003, 32'd8, 1, 0);
        step("ls_st1");
        check("ls_st1.rdy", 32'(bus.in_ready), 32'd0);
        step("ls_st2");
        step("ls_st3");
        check("ls_cnt", 32'(stall_cnt), 32'd3);
        check("ls_hold", bus.instr_out, 32'h2008_0005);
        drive(0, 32'h0, 32'h0, 0, 0);
        step("ls_drain");
        check("ls_drain.lit", bus.instr_out, 32'h2009_0003);

        // Flush with both slots full.
        drive(1, 32'hAAAA_0001, 32'd12, 1, 0);
        step("fl_two");
        drive(1, 32'hBBBB_0002, 32'd16, 0, 1);
        step("fl");
        check("fl.valid", 32'(bus.valid_out), 32'd0);
        check("fl.instr", bus.instr_out, 32'h0);
        drive(0, 32'h0, 32'h0, 0, 0);
        step("fl_after");

        // Flush and stall together.
        drive(1, 32'hCCCC_0003, 32'd20, 0, 0);
        step("fs_fill");
        drive(1, 32'hDDDD_0004, 32'd24, 1, 1);
        step("fs");
        check("fs.valid", 32'(bus.valid_out), 32'd0);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(3, 0) != 0, $urandom, $urandom,
                  $urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0);
            step("rnd");
        end

        // Counter saturation.
        async_reset();
        drive(1, 32'h0000_1234, 32'd4, 0, 0);
        step("sat_fill");
        drive(0, 32'h0, 32'h0, 1, 0);
        for (int n = 0; n < 10; n++)
            step("sat");
        check("sat.lit", 32'(stall_cnt), 32'd7);

        // Async reset while in TWO.
        drive(1, 32'h0000_5678, 32'd8, 1, 0);
        step("ar_two");
        check("ar_two.rdy", 32'(bus.in_ready), 32'd0);
        async_reset();
        check("ar.valid", 32'(bus.valid_out), 32'd0);
        drive(0, 32'h0, 32'h0, 0, 0);
        step("ar_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
